// File: rtl/dac_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_pkg
//  Description : Shared types and constants for the serial DAC driver:
//                frame-sequencer state encoding, default frame geometry and
//                the default control nibble sent ahead of each sample.
//  Revision    : 1.0  initial release
// ============================================================================
package dac_spi_pkg;

   // Frame sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   // Default frame geometry: 4 control bits followed by a 12-bit sample
   localparam int         c_CTRL_W_DEFAULT = 4;
   localparam int         c_DATA_W_DEFAULT = 12;
   localparam int         c_FRAME_W        = c_CTRL_W_DEFAULT + c_DATA_W_DEFAULT;

   // Control nibble sent ahead of the data word
   localparam logic [3:0] c_CTRL_DEFAULT   = 4'b0000;

   // States in which chip select is low and the phase timebase must run
   function automatic logic is_active(input state_t s);
      return (s == ST_SETUP) || (s == ST_SHIFT) || (s == ST_HOLD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_tx_sclk_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sclk_phase_gen
//  Description : Phase timebase for the serial DAC driver. While enabled it
//                emits a one-cycle phase_tick every DIV clocks; restart
//                clears the count synchronously so the first tick after a
//                restart lands exactly DIV cycles later.
//  Revision    : 1.0  initial release
// ============================================================================
module sclk_phase_gen
   import dac_spi_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic restart,
   output logic phase_tick
);

   localparam int                 c_CNT_W = $clog2(DIV) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);

   logic [c_CNT_W-1:0] r_cnt;

   // Cycle counter within the current DIV-long phase; never wraps past DIV-1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (restart) begin
         r_cnt <= '0;
      end else if (en) begin
         if (r_cnt == c_LAST) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
         end
      end
   end

   // Tick on the last cycle of each phase so the consumer advances on the
   // edge that ends the phase
   assign phase_tick = en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_tx
//  Description : Serial DAC driver. Captures one DDS sample per frame and
//                shifts {CTRL, sample} MSB first to an SPI DAC (CPOL=0, data
//                sampled by the DAC on rising SCLK). With din_valid tied high
//                the per-clock sample stream is decimated to the frame rate.
//  Revision    : 1.0  initial release
// ============================================================================
module dac_spi_tx
   import dac_spi_pkg::*;
#(
   parameter int                DATA_W  = c_DATA_W_DEFAULT,
   parameter int                CTRL_W  = c_CTRL_W_DEFAULT,
   parameter logic [CTRL_W-1:0] CTRL    = CTRL_W'(c_CTRL_DEFAULT),
   parameter int                DIV     = 1,
   parameter int                GAP_CYC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              dac_cs_n,
   output logic              dac_sclk,
   output logic              dac_din,
   output logic              busy,
   output logic              frame_done
);

   localparam int                 c_FRAME_BITS = CTRL_W + DATA_W;
   localparam int                 c_BIT_W      = 5;
   localparam logic [c_BIT_W-1:0] c_LAST_BIT   = c_BIT_W'(c_FRAME_BITS - 1);
   localparam int                 c_GAP_W      = $clog2(GAP_CYC) + 1;
   localparam logic [c_GAP_W-1:0] c_GAP_LAST   = c_GAP_W'(GAP_CYC - 1);

   state_t                  r_state;
   logic                    r_rst_done;
   // Holds the bits still to be sent; the bit on the wire lives in dac_din
   logic [c_FRAME_BITS-2:0] r_shift;
   logic [c_BIT_W-1:0]      r_bit_cnt;
   logic [c_GAP_W-1:0]      r_gap_cnt;

   logic                    w_active;
   logic                    w_restart;
   logic                    w_tick;
   logic                    w_accept;
   logic [c_FRAME_BITS-1:0] w_frame;

   assign w_frame   = {CTRL, din};
   assign w_active  = is_active(r_state);
   // Holding the timebase in restart outside SETUP..HOLD means it always
   // starts from zero on SETUP entry; every later phase is DIV long, so the
   // free-running count stays aligned to each phase boundary
   assign w_restart = !w_active;
   assign w_accept  = din_valid && din_ready;

   assign din_ready = r_rst_done && (r_state == ST_IDLE);
   assign busy      = r_rst_done && (r_state != ST_IDLE);

   sclk_phase_gen #(
      .DIV (DIV)
   ) u_phase_gen (
      .clk        (clk),
      .reset      (reset),
      .en         (w_active),
      .restart    (w_restart),
      .phase_tick (w_tick)
   );

   // Marks the first clock edge after reset release; holds off din_ready
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rst_done <= 1'b0;
      end else begin
         r_rst_done <= 1'b1;
      end
   end

   // Frame sequencer: state, shift register, bit/gap counters and all
   // registered SPI outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_gap_cnt  <= '0;
         dac_cs_n   <= 1'b1;
         dac_sclk   <= 1'b0;
         dac_din    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state  <= ST_SETUP;
                  r_shift  <= w_frame[c_FRAME_BITS-2:0];
                  dac_din  <= w_frame[c_FRAME_BITS-1];
                  dac_cs_n <= 1'b0;
                  dac_sclk <= 1'b0;
               end
            end

            ST_SETUP: begin
               if (w_tick) begin
                  r_state   <= ST_SHIFT;
                  r_bit_cnt <= '0;
               end
            end

            ST_SHIFT: begin
               if (w_tick) begin
                  if (!dac_sclk) begin
                     dac_sclk <= 1'b1;
                  end else begin
                     // Falling SCLK: the DAC has taken the bit, present the
                     // next one while SCLK is low
                     dac_sclk <= 1'b0;
                     if (r_bit_cnt == c_LAST_BIT) begin
                        r_state <= ST_HOLD;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                        dac_din   <= r_shift[c_FRAME_BITS-2];
                        r_shift   <= {r_shift[c_FRAME_BITS-3:0], 1'b0};
                     end
                  end
               end
            end

            ST_HOLD: begin
               if (w_tick) begin
                  r_state    <= ST_GAP;
                  r_gap_cnt  <= '0;
                  dac_cs_n   <= 1'b1;
                  frame_done <= 1'b1;
               end
            end

            ST_GAP: begin
               if (r_gap_cnt == c_GAP_LAST) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
               end
            end

            default: begin
               r_state  <= ST_IDLE;
               dac_cs_n <= 1'b1;
               dac_sclk <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_spi_tx
//  Description : Self-checking bench for dac_spi_tx. Two instances (DIV=1 and
//                DIV=3) share one clock. Accepted samples are queued as
//                expected frames; a monitor rebuilds each frame from the bits
//                on the SCLK rises and checks data and timing at frame_done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dac_spi_tx;

   localparam int GAP = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst_n;
   logic [1:0]  din_valid;
   logic [11:0] din [2];
   logic [1:0]  din_ready, dac_cs_n, dac_sclk, dac_din, busy, frame_done;

   dac_spi_tx #(
      .DATA_W(12), .CTRL_W(4), .CTRL(4'b0000), .DIV(1), .GAP_CYC(GAP)
   ) u_dut_div1 (
      .clk(clk), .reset(rst_n[0]), .din(din[0]), .din_valid(din_valid[0]),
      .din_ready(din_ready[0]), .dac_cs_n(dac_cs_n[0]), .dac_sclk(dac_sclk[0]),
      .dac_din(dac_din[0]), .busy(busy[0]), .frame_done(frame_done[0])
   );

   dac_spi_tx #(
      .DATA_W(12), .CTRL_W(4), .CTRL(4'b0000), .DIV(3), .GAP_CYC(GAP)
   ) u_dut_div3 (
      .clk(clk), .reset(rst_n[1]), .din(din[1]), .din_valid(din_valid[1]),
      .din_ready(din_ready[1]), .dac_cs_n(dac_cs_n[1]), .dac_sclk(dac_sclk[1]),
      .dac_din(dac_din[1]), .busy(busy[1]), .frame_done(frame_done[1])
   );

   typedef struct packed {
      int          idx;
      logic [15:0] frame;
   } exp_t;

   exp_t        exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   int          acc_cyc  [2];
   int          last_chg [2];
   int          cs_fall  [2];
   int          rises    [2];
   int          done_cnt [2];
   logic [15:0] rx       [2];
   logic [1:0]  in_frame, b2b, last_b2b, prev_cs, prev_sclk, prev_din;

   task automatic chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Monitor / scoreboard: samples on the falling clock edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         int   dv;
         exp_t e;
         dv = (i == 0) ? 1 : 3;
         if (!rst_n[i]) begin
            in_frame[i] = 1'b0;
            for (int k = exp_q.size() - 1; k >= 0; k--)
               if (exp_q[k].idx == i) exp_q.delete(k);
         end else begin
            if (din_valid[i] && din_ready[i]) begin
               if (b2b[i] && last_b2b[i])
                  chk("accept_period", cyc - acc_cyc[i], 1 + 34*dv + GAP);
               exp_q.push_back('{idx: i, frame: {4'h0, din[i]}});
               acc_cyc[i]  = cyc;
               last_b2b[i] = b2b[i];
            end
            if (prev_cs[i] && !dac_cs_n[i]) begin
               chk("cs_fall_latency", cyc - acc_cyc[i], 1);
               cs_fall[i]  = cyc;
               in_frame[i] = 1'b1;
               rises[i]    = 0;
               rx[i]       = 16'h0;
            end
            if (!prev_sclk[i] && dac_sclk[i]) begin
               rises[i] = rises[i] + 1;
               rx[i]    = {rx[i][14:0], dac_din[i]};
               if (rises[i] == 1) chk("first_rise", cyc - acc_cyc[i], 1 + 2*dv);
               else               chk("low_phase", cyc - last_chg[i], dv);
               last_chg[i] = cyc;
            end
            if (prev_sclk[i] && !dac_sclk[i]) begin
               chk("high_phase", cyc - last_chg[i], dv);
               last_chg[i] = cyc;
            end
            if (!prev_cs[i] && dac_cs_n[i] && in_frame[i]) begin
               chk("cs_low_len", cyc - cs_fall[i], 34*dv);
               chk("hold_len", cyc - last_chg[i], dv);
            end
            if (frame_done[i]) begin
               done_cnt[i] = done_cnt[i] + 1;
               chk("done_in_frame", int'(in_frame[i]), 1);
               if (in_frame[i]) begin
                  chk("done_time", cyc - acc_cyc[i], 1 + 34*dv);
                  chk("rise_count", rises[i], 16);
                  chk("exp_available", int'(exp_q.size() > 0), 1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     chk("frame_inst", e.idx, i);
                     chk("frame_data", int'(rx[i]), int'(e.frame));
                  end
               end
               in_frame[i] = 1'b0;
            end
            if (dac_din[i] != prev_din[i]) begin
               chk("din_change_sclk_high", int'(dac_sclk[i]), 0);
               chk("din_change_cs_high", int'(dac_cs_n[i]), 0);
            end
         end
         prev_cs[i]   = dac_cs_n[i];
         prev_sclk[i] = dac_sclk[i];
         prev_din[i]  = dac_din[i];
      end
   end

   task automatic send(input int i, input logic [11:0] v);
      int n;
      n = 0;
      @(posedge clk); #2;
      din[i]       = v;
      din_valid[i] = 1'b1;
      while (!din_ready[i] && n < 300) begin
         @(posedge clk); #2;
         n++;
      end
      chk("accept_in_time", int'(n < 300), 1);
      @(posedge clk); #2;
      din_valid[i] = 1'b0;
      din[i]       = ~v;   // mid-frame change must not affect the frame
   endtask

   task automatic wait_done(input int i, input int target, input int limit);
      int n;
      n = 0;
      while (done_cnt[i] < target && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      chk("frame_count", done_cnt[i], target);
   endtask

   task automatic wait_idle(input int i, input int limit);
      int n;
      n = 0;
      while (busy[i] && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      chk("drain_idle", int'(busy[i]), 0);
   endtask

   task automatic stream(input int i, input int ncyc, input logic [11:0] step);
      b2b[i] = 1'b1;
      @(posedge clk); #2;
      din_valid[i] = 1'b1;
      repeat (ncyc) begin
         @(posedge clk); #2;
         din[i] = din[i] + step;
      end
      din_valid[i] = 1'b0;
      b2b[i]       = 1'b0;
   endtask

   initial begin
      int saved;
      rst_n     = 2'b00;
      din_valid = 2'b00;
      din[0]    = 12'h000;
      din[1]    = 12'h000;
      b2b       = 2'b00;
      last_b2b  = 2'b00;
      in_frame  = 2'b00;
      prev_cs   = 2'b11;
      prev_sclk = 2'b00;
      prev_din  = 2'b00;
      for (int i = 0; i < 2; i++) begin
         acc_cyc[i] = 0; last_chg[i] = 0; cs_fall[i] = 0;
         rises[i] = 0; done_cnt[i] = 0; rx[i] = 16'h0;
      end

      // Reset held for 3 cycles
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", int'(dac_cs_n[0]), 1);
      chk("rst_sclk", int'(dac_sclk[0]), 0);
      chk("rst_din", int'(dac_din[0]), 0);
      chk("rst_frame_done", int'(frame_done[0]), 0);
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_din_ready", int'(din_ready[0]), 0);
      chk("rst_cs_n_div3", int'(dac_cs_n[1]), 1);

      // Release: din_ready must wait for the next clock edge
      @(negedge clk); #1;
      rst_n = 2'b11;
      #1;
      chk("ready_at_release", int'(din_ready[0]), 0);
      @(posedge clk); #1;
      chk("ready_one_cycle_after", int'(din_ready[0]), 1);

      // Single frame 12'hABC on DIV=1
      send(0, 12'hABC);
      wait_done(0, 1, 100);
      repeat (10) @(negedge clk);
      #1;
      chk("single_done_once", done_cnt[0], 1);

      // DDS ramp with din_valid held high
      din[0] = 12'h100;
      stream(0, 160, 12'h011);
      wait_idle(0, 100);

      // DIV=3 single frame then back-to-back stream
      send(1, 12'h5A3);
      wait_done(1, 1, 200);
      din[1] = 12'hF00;
      stream(1, 230, 12'h007);
      wait_idle(1, 150);

      // Reset mid-frame after bit 7, then a clean frame of 12'h123
      saved = done_cnt[0];
      send(0, 12'h7E1);
      begin
         int n;
         n = 0;
         while (!(rises[0] >= 8 && !dac_sclk[0]) && n < 100) begin
            @(negedge clk); #1;
            n++;
         end
         chk("reach_bit7", int'(n < 100), 1);
      end
      #2;
      rst_n[0] = 1'b0;
      #1;
      chk("midrst_cs_n", int'(dac_cs_n[0]), 1);
      chk("midrst_sclk", int'(dac_sclk[0]), 0);
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      rst_n[0] = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      chk("midrst_no_done", done_cnt[0], saved);
      send(0, 12'h123);
      wait_done(0, saved + 1, 120);
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
